// File: rtl/ir_pkg.sv
// Shared constants and helpers for the instruction-register prefetch queue.
package ir_pkg;

  localparam int OP_W_DEF  = 5;
  localparam int ARG_W_DEF = 12;
  localparam int DEPTH_DEF = 4;
  localparam int NOP       = 0;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ir_queue_mem.sv
// Prefetch queue storage: tail write port plus head read/modify port.
module ir_queue_mem #(
  parameter int W     = 17,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] haddr_i,
  output logic [W-1:0]  hdata_o,
  input  logic          mod_en_i,
  input  logic [W-1:0]  mod_data_i
);

  logic [W-1:0] mem_q [DEPTH];
  logic         collide;

  assign hdata_o = mem_q[haddr_i];
  assign collide = we_i && (waddr_i == haddr_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (mod_en_i && !collide) mem_q[haddr_i] <= mod_data_i;
    end
  end

endmodule

// File: rtl/ir_prefetch_queue.sv
// Instruction prefetch queue with handshakes, flush and head auto-increment.
// Optional even-parity protection with sticky par_err when IR_PARITY_EN is defined.
module ir_prefetch_queue
  import ir_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int ARG_W = ARG_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_W+ARG_W-1:0]     in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OP_W-1:0]           opcode,
  output logic [ARG_W-1:0]          operand,
  input  logic                      inc_en,
  input  logic                      flush,
  output logic [cnt_w(DEPTH)-1:0]   count
`ifdef IR_PARITY_EN
  ,
  output logic                      par_err
`endif
);

  localparam int DW = OP_W + ARG_W;
  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);
`ifdef IR_PARITY_EN
  localparam int W  = DW + 1;
`else
  localparam int W  = DW;
`endif
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;

  logic          push, pop, inc;
  logic          empty;
  logic [W-1:0]  wdata, hdata, mod_data;
  logic [DW-1:0] head, inc_word;

  assign empty     = (count_q == '0);
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = !empty;
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign inc  = inc_en && out_valid && !pop;

  assign head     = hdata[DW-1:0];
  assign inc_word = {head[DW-1:ARG_W], head[ARG_W-1:0] + ARG_W'(1)};

`ifdef IR_PARITY_EN
  assign wdata    = {^in_data, in_data};
  assign mod_data = {^inc_word, inc_word};
`else
  assign wdata    = in_data;
  assign mod_data = inc_word;
`endif

  assign opcode  = empty ? OP_W'(NOP) : head[DW-1:ARG_W];
  assign operand = empty ? '0 : head[ARG_W-1:0];

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  ir_queue_mem #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk        (clk),
    .rst        (rst),
    .we_i       (push && !flush),
    .waddr_i    (wr_ptr_q),
    .wdata_i    (wdata),
    .haddr_i    (rd_ptr_q),
    .hdata_o    (hdata),
    .mod_en_i   (inc && !flush),
    .mod_data_i (mod_data)
  );

`ifdef IR_PARITY_EN
  logic par_err_q, par_err_d;

  // A stored word with correct even parity xors to zero including its parity bit.
  always_comb begin
    par_err_d = par_err_q;
    if (flush) par_err_d = 1'b0;
    else if (out_valid && (^hdata)) par_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Directed, table-driven self-checking bench for ir_prefetch_queue.
module tb_ir_prefetch_queue;

  localparam int OP_W  = 5;
  localparam int ARG_W = 12;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [OP_W+ARG_W-1:0] in_data = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [OP_W-1:0]       opcode;
  logic [ARG_W-1:0]      operand;
  logic                  inc_en = 1'b0;
  logic                  flush = 1'b0;
  logic [CW-1:0]         count;
`ifdef IR_PARITY_EN
  logic                  par_err;
`endif

  ir_prefetch_queue #(
    .OP_W  (OP_W),
    .ARG_W (ARG_W),
    .DEPTH (DEPTH)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .opcode    (opcode),
    .operand   (operand),
    .inc_en    (inc_en),
    .flush     (flush),
    .count     (count)
`ifdef IR_PARITY_EN
    ,
    .par_err   (par_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  op;
    logic [11:0] arg;
    logic        ordy;
    logic        inc;
    logic        fl;
    logic        e_ov;
    logic [4:0]  e_op;
    logic [11:0] e_arg;
    int          e_cnt;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [4:0] op,
                     input logic [11:0] arg, input logic ordy,
                     input logic inc, input logic fl, input logic e_ov,
                     input logic [4:0] e_op, input logic [11:0] e_arg,
                     input int e_cnt, input logic e_rdy);
    vec_t v;
    v = '{iv, op, arg, ordy, inc, fl, e_ov, e_op, e_arg, e_cnt, e_rdy};
    vecs.push_back(v);
  endtask

  task automatic chk_all(input string tag, input logic e_ov,
                         input logic [4:0] e_op, input logic [11:0] e_arg,
                         input int e_cnt, input logic e_rdy);
    chk({tag, " out_valid"}, int'(out_valid), int'(e_ov));
    chk({tag, " opcode"}, int'(opcode), int'(e_op));
    chk({tag, " operand"}, int'(operand), int'(e_arg));
    chk({tag, " count"}, int'(count), e_cnt);
    chk({tag, " in_ready"}, int'(in_ready), int'(e_rdy));
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    in_valid  = v.iv;
    in_data   = {v.op, v.arg};
    out_ready = v.ordy;
    inc_en    = v.inc;
    flush     = v.fl;
    @(posedge clk);
    #1;
    chk_all(tag, v.e_ov, v.e_op, v.e_arg, v.e_cnt, v.e_rdy);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inc_en    = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    // push 1/2AB, 0A/005, then fill and refuse
    add(1, 5'h01, 12'h2AB, 0, 0, 0, 1, 5'h01, 12'h2AB, 1, 1);
    add(1, 5'h0A, 12'h005, 0, 0, 0, 1, 5'h01, 12'h2AB, 2, 1);
    add(1, 5'h02, 12'h100, 0, 0, 0, 1, 5'h01, 12'h2AB, 3, 1);
    add(1, 5'h03, 12'h200, 0, 0, 0, 1, 5'h01, 12'h2AB, 4, 0);
    add(1, 5'h04, 12'h300, 0, 0, 0, 1, 5'h01, 12'h2AB, 4, 0);
    add(1, 5'h04, 12'h300, 1, 0, 0, 1, 5'h0A, 12'h005, 3, 1);
    add(1, 5'h04, 12'h300, 0, 0, 0, 1, 5'h0A, 12'h005, 4, 0);
    // drain
    add(0, 5'h00, 12'h000, 1, 0, 0, 1, 5'h02, 12'h100, 3, 1);
    add(0, 5'h00, 12'h000, 1, 0, 0, 1, 5'h03, 12'h200, 2, 1);
    add(0, 5'h00, 12'h000, 1, 0, 0, 1, 5'h04, 12'h300, 1, 1);
    add(0, 5'h00, 12'h000, 1, 0, 0, 0, 5'h00, 12'h000, 0, 1);
    // pop and inc on empty are ignored
    add(0, 5'h00, 12'h000, 1, 1, 0, 0, 5'h00, 12'h000, 0, 1);
    // auto-increment with operand wrap
    add(1, 5'h07, 12'hFFE, 0, 0, 0, 1, 5'h07, 12'hFFE, 1, 1);
    add(0, 5'h00, 12'h000, 0, 1, 0, 1, 5'h07, 12'hFFF, 1, 1);
    add(0, 5'h00, 12'h000, 0, 1, 0, 1, 5'h07, 12'h000, 1, 1);
    add(0, 5'h00, 12'h000, 0, 1, 0, 1, 5'h07, 12'h001, 1, 1);
    // simultaneous push/pop, then inc+pop: pop wins
    add(1, 5'h08, 12'h010, 1, 0, 0, 1, 5'h08, 12'h010, 1, 1);
    add(1, 5'h09, 12'h020, 0, 0, 0, 1, 5'h08, 12'h010, 2, 1);
    add(0, 5'h00, 12'h000, 1, 1, 0, 1, 5'h09, 12'h020, 1, 1);
    // reach count=3 then flush with push+pop+inc
    add(1, 5'h0A, 12'h111, 0, 0, 0, 1, 5'h09, 12'h020, 2, 1);
    add(1, 5'h0B, 12'h222, 0, 0, 0, 1, 5'h09, 12'h020, 3, 1);
    add(1, 5'h0C, 12'h333, 1, 1, 1, 0, 5'h00, 12'h000, 0, 1);
    add(1, 5'h0D, 12'h444, 0, 0, 0, 1, 5'h0D, 12'h444, 1, 1);
    add(1, 5'h0E, 12'h555, 0, 0, 0, 1, 5'h0D, 12'h444, 2, 1);

    #12;
    chk_all("reset", 0, 5'h00, 12'h000, 0, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));
    idle();

    // asynchronous reset mid-stream with count=2
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 5'h00, 12'h000, 0, 1);
    @(negedge clk);
    rst = 1'b0;
    begin
      vec_t v;
      v = '{1, 5'h01, 12'h001, 0, 0, 0, 1, 5'h01, 12'h001, 1, 1};
      apply(v, "post_rst");
    end
    idle();

`ifdef IR_PARITY_EN
    @(posedge clk);
    #1;
    chk("par_clean", int'(par_err), 0);
    u_dut.u_mem.mem_q[0][OP_W+ARG_W] = 1'b1;
    @(posedge clk);
    #1;
    chk("par_set", int'(par_err), 1);
    @(posedge clk);
    #1;
    chk("par_sticky", int'(par_err), 1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("par_flush", int'(par_err), 0);
    idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_prefetch_queue.md
Name: ir_prefetch_queue

Overview:
- Parametrised instruction-register successor: a DEPTH-entry prefetch queue of fetched words.
- Each word is split into an opcode (upper OP_W bits) and an operand (lower ARG_W bits).
- Sits between instruction memory fetch and the decoder. The head entry is the current instruction; its operand feeds the bus.
- Adds valid/ready handshakes, flush, in-place operand increment (auto-index) and an occupancy count.

Parameters:
- OP_W, 5, opcode field width (bits).
- ARG_W, 12, operand field width (bits).
- DEPTH, 4, queue entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch word present.
- in_ready  out  1  queue can accept a word; equals !full.
- in_data  in  OP_W+ARG_W  fetched word; opcode in [OP_W+ARG_W-1:ARG_W], operand in [ARG_W-1:0].
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decoder consumes the head.
- opcode  out  OP_W  head opcode; 0 when empty.
- operand  out  ARG_W  head operand; 0 when empty.
- inc_en  in  1  increment the head operand in place.
- flush  in  1  discard all entries (branch taken).
- count  out  $clog2(DEPTH)+1  entries held.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - Pointers 0, count 0, all storage 0.
  - in_ready=1, out_valid=0, opcode=0, operand=0.
- Push:
  - A push occurs when in_valid && in_ready at a clk edge; the word is written at the tail.
  - Latency: a word pushed into an empty queue appears on out_valid/opcode/operand in the next cycle. There is no combinational bypass from in_data.
- Pop:
  - A pop occurs when out_valid && out_ready; the head advances.
- Head outputs: opcode and operand are read directly from the head storage entry, and are forced to 0 when count==0.
- in_ready = (count != DEPTH). It does not look ahead to a same-cycle pop, so a full queue refuses a push even while popping.
- Simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. count saturates by construction: push is blocked at DEPTH, pop is blocked at 0.
- inc_en:
  - If out_valid and no pop this cycle, head operand <= operand+1, modulo 2^ARG_W (0xFFF -> 0x000 at default width).
  - The opcode is untouched.
  - Ignored when empty. Ignored when a pop occurs in the same cycle (pop wins).
- flush:
  - Highest priority. Next cycle count=0 and out_valid=0.
  - Any same-cycle push, pop and inc are discarded.
  - in_ready stays as computed from the current count during the flush cycle; the flushed push is lost and the fetch unit must re-issue it.
- Priority: rst > flush > pop > inc. Push is independent of pop and inc.

Optional Feature:
- Macro: IR_PARITY_EN.
- With it defined:
  - Each entry stores an extra even-parity bit computed from in_data at push.
  - Output par_err (1 bit) is registered. It is set the cycle after a head entry whose stored parity mismatches its contents becomes visible.
  - par_err is sticky until rst or flush.
  - inc_en recomputes the parity bit of the head.
- Without it: no parity storage and no par_err port.

Decomposition:
- Package ir_pkg:
  - Default OP_W/ARG_W/DEPTH constants.
  - NOP opcode constant (0).
  - Helper function for the count width.
- Sub-module ir_queue_mem: DEPTH x (OP_W+ARG_W[+1]) register array with a write port and a head read/modify port (for inc).
- Pointer, count, handshake and flush logic stay in the top module.

Test Plan:
- Reset then push 0x1_2AB and 0x0A_005 back-to-back:
  - Cycle after first push: out_valid=1, opcode=0x01, operand=0x2AB, count=1.
  - Next cycle: count=2.
- Fill with 4 words while out_ready=0:
  - in_ready=0 at count=4.
  - A fifth in_valid is refused.
  - Pop with in_valid held: count goes to 3, no push that cycle; the push completes on the following cycle.
- Head operand 0xFFE, inc_en for 3 cycles with out_ready=0:
  - operand goes 0xFFF, 0x000, 0x001; opcode unchanged.
- inc_en and pop in the same cycle with head operand 0x010:
  - The entry is popped unmodified.
  - The next head shows its own pushed operand.
- flush asserted with count=3 and simultaneous push and pop:
  - Next cycle count=0, out_valid=0, opcode=0, operand=0; the pushed word is absent.
- Assert rst asynchronously mid-stream (count=2, between clk edges):
  - Outputs go to reset values immediately, without waiting for an edge.
- With IR_PARITY_EN: force a parity bit flip in storage on the head entry:
  - par_err=1 on the next cycle; it stays 1 until flush.
